// File: rtl/mb16_dot_acc.sv
// Saturating dot-product accumulator behind the 16-bit Booth multiplier stage.
// It sums LEN signed products per group and holds each result in a valid/ready output register.
module mb16_dot_acc #(
  parameter int PWIDTH = 32,
  parameter int AWIDTH = 40,
  parameter int LEN    = 16,
  parameter int CWIDTH = 5
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     clear,
  input  logic                     in_valid,
  input  logic signed [PWIDTH-1:0] product,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [AWIDTH-1:0] acc_out,
  output logic                     ovf
);

  localparam logic [CWIDTH-1:0] LAST_CNT = CWIDTH'(LEN - 1);
  localparam logic [AWIDTH-1:0] ACC_MAX  = {1'b0, {(AWIDTH-1){1'b1}}};
  localparam logic [AWIDTH-1:0] ACC_MIN  = {1'b1, {(AWIDTH-1){1'b0}}};

  logic [AWIDTH-1:0] acc_r;
  logic [CWIDTH-1:0] cnt_r;
  logic              sticky_r;

  logic              last_s;
  logic              beat_s;
  logic [PWIDTH-1:0] prod_s;
  logic [AWIDTH:0]   sum_s;
  logic              clamp_s;
  logic [AWIDTH-1:0] sat_s;

  // The two top bits of the one-bit-wider sum disagree exactly when it left the signed range.
  function automatic logic sat_clamp(input logic [AWIDTH:0] s);
    return s[AWIDTH] ^ s[AWIDTH-1];
  endfunction

  function automatic logic [AWIDTH-1:0] sat_value(input logic [AWIDTH:0] s);
    logic [AWIDTH-1:0] v;
    if (sat_clamp(s)) begin
      v = s[AWIDTH] ? ACC_MIN : ACC_MAX;
    end else begin
      v = s[AWIDTH-1:0];
    end
    return v;
  endfunction

  // Handshake decode and saturating add; product is gated so an idle X never reaches the sum.
  always_comb begin
    last_s   = (cnt_r == LAST_CNT);
    in_ready = ~clear & ~(out_valid & ~out_ready & last_s);
    beat_s   = in_valid & in_ready;
    prod_s   = beat_s ? product : {PWIDTH{1'b0}};
    sum_s    = {acc_r[AWIDTH-1], acc_r} + {{(AWIDTH+1-PWIDTH){prod_s[PWIDTH-1]}}, prod_s};
    clamp_s  = sat_clamp(sum_s);
    sat_s    = sat_value(sum_s);
  end

  // Running accumulator, beat counter and in-group saturation flag.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      acc_r    <= {AWIDTH{1'b0}};
      cnt_r    <= {CWIDTH{1'b0}};
      sticky_r <= 1'b0;
    end else if (clear) begin
      acc_r    <= {AWIDTH{1'b0}};
      cnt_r    <= {CWIDTH{1'b0}};
      sticky_r <= 1'b0;
    end else if (beat_s) begin
      if (last_s) begin
        acc_r    <= {AWIDTH{1'b0}};
        cnt_r    <= {CWIDTH{1'b0}};
        sticky_r <= 1'b0;
      end else begin
        acc_r    <= sat_s;
        cnt_r    <= cnt_r + CWIDTH'(1);
        sticky_r <= sticky_r | clamp_s;
      end
    end else begin
      acc_r    <= acc_r;
      cnt_r    <= cnt_r;
      sticky_r <= sticky_r;
    end
  end

  // Result register: a closing beat loads it, even while the previous result is being consumed.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      acc_out   <= {AWIDTH{1'b0}};
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else if (beat_s && last_s) begin
      acc_out   <= sat_s;
      ovf       <= sticky_r | clamp_s;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      acc_out   <= acc_out;
      ovf       <= ovf;
      out_valid <= 1'b0;
    end else begin
      acc_out   <= acc_out;
      ovf       <= ovf;
      out_valid <= out_valid;
    end
  end

endmodule
